adder_sub_4bit: RTL and testbench

- Registered N-bit (default 4) two's-complement adder/subtractor built from a gate-level ripple-carry chain.
- Select chooses A+B or A−B.
- Sum, carry-out and signed overflow are registered once with a valid strobe.
- Used as a small arithmetic leaf in datapath and lab-level ALU blocks.

---
 rtl/adder_sub_4bit.sv | 89 ++++++++
 tb/tb_adder_sub_4bit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/adder_sub_4bit.sv
// Registered ripple-carry adder/subtractor; optional zero/negative status
// outputs are enabled with `define ADDSUB_STATUS_FLAGS_EN.
module adder_sub_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
`ifdef ADDSUB_STATUS_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative
`endif
);

    if (WIDTH < 2) begin : g_width_chk
        $error("adder_sub_4bit: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] w_beff;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_c;
    logic             w_ovf;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
    assign w_c[0] = select;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign w_beff[i]  = b[i] ^ select;
        assign w_p[i]     = a[i] ^ w_beff[i];
        assign w_s[i]     = w_p[i] ^ w_c[i];
        assign w_c[i+1]   = (a[i] & w_beff[i]) | (w_c[i] & w_p[i]);
    end

    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_overflow;
    logic             r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum      <= w_s;
                r_carry    <= w_c[WIDTH];
                r_overflow <= w_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;

`ifdef ADDSUB_STATUS_FLAGS_EN
    logic r_zero;
    logic r_negative;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else if (in_valid) begin
            r_zero     <= ~|w_s;
            r_negative <= w_s[WIDTH-1];
        end
    end

    assign zero     = r_zero;
    assign negative = r_negative;
`endif

endmodule

// File: tb/tb_adder_sub_4bit.sv
// Randomised self-checking bench for adder_sub_4bit against an
// arithmetic reference model (integer add/subtract with range checks).
module tb_adder_sub_4bit;

    localparam int W = 4;
`ifdef ADDSUB_STATUS_FLAGS_EN
    localparam int XW = 2;
`else
    localparam int XW = 0;
`endif
    localparam int OW = W + 3 + XW;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         select = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;
    logic         out_valid;
`ifdef ADDSUB_STATUS_FLAGS_EN
    logic         zero;
    logic         negative;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic [OW-1:0] ref_out = '0;

    adder_sub_4bit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .select   (select),
        .in_valid (in_valid),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow),
        .out_valid(out_valid)
`ifdef ADDSUB_STATUS_FLAGS_EN
        ,
        .zero     (zero),
        .negative (negative)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] obs();
        return {sum, carry, overflow
`ifdef ADDSUB_STATUS_FLAGS_EN
                , zero, negative
`endif
                , out_valid};
    endfunction

    // Packs an expected result in the same field order as obs().
    function automatic logic [OW-1:0] mk(logic [W-1:0] s, logic c,
                                         logic o, logic v);
        return {s, c, o
`ifdef ADDSUB_STATUS_FLAGS_EN
                , (s == '0), s[W-1]
`endif
                , v};
    endfunction

    // Plain integer arithmetic: carry is unsigned, overflow is signed range.
    function automatic logic [OW-1:0] model(logic [W-1:0] x, logic [W-1:0] y,
                                            logic sub);
        int ux, uy, sx, sy, r, sr;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W-1))) ? uy - (1 << W) : uy;
        if (sub) begin
            r  = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy;
            c  = (r >= (1 << W));
            sr = sx + sy;
        end
        o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        r = r & ((1 << W) - 1);
        return mk(r[W-1:0], c, o, 1'b1);
    endfunction

    // Applies one cycle of stimulus and advances the reference state.
    task automatic drive(logic r, logic v, logic [W-1:0] x,
                         logic [W-1:0] y, logic s);
        rst = r;
        in_valid = v;
        a = x;
        b = y;
        select = s;
        @(posedge clk);
        if (r) ref_out = '0;
        else if (v) ref_out = model(x, y, s);
        else ref_out[0] = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 4'hA, 4'h5, 1'b1);
        n_total++;
        if (obs() !== '0)
            $display("FAIL reset got=%h exp=%h", obs(), {OW{1'b0}});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic         vs [8];
        logic [OW-1:0] ve [8];
        va[0] = 4'b0000; vb[0] = 4'b0000; vs[0] = 0; ve[0] = mk(4'b0000, 0, 0, 1);
        va[1] = 4'b1000; vb[1] = 4'b0101; vs[1] = 1; ve[1] = mk(4'b0011, 1, 1, 1);
        va[2] = 4'b1111; vb[2] = 4'b1000; vs[2] = 1; ve[2] = mk(4'b0111, 1, 0, 1);
        va[3] = 4'b0111; vb[3] = 4'b0001; vs[3] = 0; ve[3] = mk(4'b1000, 0, 1, 1);
        va[4] = 4'b0011; vb[4] = 4'b0101; vs[4] = 1; ve[4] = mk(4'b1110, 0, 0, 1);
        va[5] = 4'b1010; vb[5] = 4'b1010; vs[5] = 1; ve[5] = mk(4'b0000, 1, 0, 1);
        va[6] = 4'b0000; vb[6] = 4'b0000; vs[6] = 1; ve[6] = mk(4'b0000, 1, 0, 1);
        va[7] = 4'b1000; vb[7] = 4'b0001; vs[7] = 1; ve[7] = mk(4'b0111, 1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, va[i], vb[i], vs[i]);
            n_total++;
            if (obs() !== ve[i])
                $display("FAIL directed_%0d got=%h exp=%h", i, obs(), ve[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [OW-1:0] e;
        drive(1'b0, 1'b1, 4'b0110, 4'b0011, 1'b0);
        e = mk(4'b1001, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
            n_total++;
            if (obs() !== e)
                $display("FAIL hold_%0d got=%h exp=%h", i, obs(), e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_with_valid();
        drive(1'b1, 1'b1, 4'b0111, 4'b0111, 1'b0);
        n_total++;
        if (obs() !== '0)
            $display("FAIL rst_with_valid got=%h exp=%h", obs(), {OW{1'b0}});
        else n_pass++;
    endtask

    task automatic test_midstream_reset();
        logic [OW-1:0] e;
        drive(1'b0, 1'b1, 4'b0101, 4'b0110, 1'b0);
        drive(1'b1, 1'b1, 4'b1100, 4'b0001, 1'b1);
        n_total++;
        if (obs() !== '0)
            $display("FAIL midstream_rst got=%h exp=%h", obs(), {OW{1'b0}});
        else n_pass++;
        drive(1'b0, 1'b1, 4'b1100, 4'b0001, 1'b1);
        e = mk(4'b1011, 1, 0, 1);
        n_total++;
        if (obs() !== e)
            $display("FAIL midstream_resume got=%h exp=%h", obs(), e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85),
                  4'($urandom), 4'($urandom), 1'($urandom));
            n_total++;
            if (obs() !== ref_out)
                $display("FAIL random_%0d a=%h b=%h sel=%b got=%h exp=%h",
                         i, a, b, select, obs(), ref_out);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_with_valid();
        test_midstream_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
